// File: rtl/dlx_mem_ctrl_pkg.sv
// Shared encodings for the DLX memory bus controller: access sizes, error causes, FSM states.
package dlx_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MOP_WORD   = 2'b00,
    MOP_HALF_S = 2'b01,
    MOP_BYTE_S = 2'b10,
    MOP_BYTE_U = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ALIGN   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_BOTH    = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/dlx_mem_align.sv
// Big-endian lane logic: byte enables, store steering, load extraction/extension, misalign detect.
module dlx_mem_align
  import dlx_mem_ctrl_pkg::*;
(
  input  mem_op_e     st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_misaligned,
  input  mem_op_e     ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Sub-word stores are replicated across lanes; the byte enables pick the live lane.
  always_comb begin
    st_be         = 4'b1111;
    st_wdata      = st_data;
    st_misaligned = 1'b0;
    case (st_op)
      MOP_WORD: begin
        st_misaligned = (st_off != 2'b00);
      end
      MOP_HALF_S: begin
        st_misaligned = st_off[0];
        st_be         = st_off[1] ? 4'b0011 : 4'b1100;
        st_wdata      = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1000 >> st_off;
        st_wdata = {4{st_data[7:0]}};
      end
    endcase
  end

  always_comb begin
    ld_half = ld_off[1] ? ld_raw[15:0] : ld_raw[31:16];
    case (ld_off)
      2'd0:    ld_byte = ld_raw[31:24];
      2'd1:    ld_byte = ld_raw[23:16];
      2'd2:    ld_byte = ld_raw[15:8];
      default: ld_byte = ld_raw[7:0];
    endcase
    case (ld_op)
      MOP_WORD:   ld_data = ld_raw;
      MOP_HALF_S: ld_data = {{16{ld_half[15]}}, ld_half};
      MOP_BYTE_S: ld_data = {{24{ld_byte[7]}}, ld_byte};
      default:    ld_data = {24'b0, ld_byte};
    endcase
  end

endmodule

// File: rtl/dlx_mem_ctrl.sv
// DLX memory bus controller: turns CU MemRead/MemWrite strobes into single-outstanding
// req/ack word transactions, generating MemWait and formatted load data.
module dlx_mem_ctrl
  import dlx_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        Reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemOP,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        MemWait,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic        Err,
  output logic [1:0]  ErrCode,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_op_e     op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic [31:0] ld_data;

  // Store side sees the live CU inputs (used in IDLE); load side uses the latched op/offset.
  dlx_mem_align u_align (
    .st_op         (mem_op_e'(MemOP)),
    .st_off        (Addr[1:0]),
    .st_data       (WrData),
    .st_be         (st_be),
    .st_wdata      (st_wdata),
    .st_misaligned (st_misaligned),
    .ld_op         (op_q),
    .ld_off        (off_q),
    .ld_raw        (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (MemRead && MemWrite) begin
          state_d    = ST_DONE;
          err_d      = 1'b1;
          err_code_d = ERR_BOTH;
        end else if (MemRead || MemWrite) begin
          op_d  = mem_op_e'(MemOP);
          off_d = Addr[1:0];
          if (st_misaligned) begin
            state_d    = ST_DONE;
            err_d      = 1'b1;
            err_code_d = ERR_ALIGN;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {Addr[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      ST_REQ: begin
        // Strobes are deliberately ignored here: an issued bus cycle always runs to completion.
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rd_data_d  = ld_data;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          rd_data_d  = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= MOP_WORD;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign MemWait   = (MemRead | MemWrite) & (state_q != ST_DONE);
  assign RdData    = rd_data_q;
  assign RdValid   = rd_valid_q;
  assign Err       = err_q;
  assign ErrCode   = err_code_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// Directed bench for dlx_mem_ctrl: bench acts as CU and as a memory with programmable ack delay.
module tb_dlx_mem_ctrl;

  logic        clock = 1'b0;
  logic        Reset_n;
  logic        MemRead, MemWrite;
  logic [1:0]  MemOP;
  logic [31:0] Addr, WrData;
  logic        MemWait;
  logic [31:0] RdData;
  logic        RdValid, Err;
  logic [1:0]  ErrCode;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int nvec = 0;
  int nmis = 0;

  int          mw_cyc, req_cyc;
  logic        o_done, o_we, o_rdv, o_err;
  logic [3:0]  o_be;
  logic [1:0]  o_ec;
  logic [31:0] o_addr, o_wdata, o_rd;

  always #5 clock = ~clock;

  dlx_mem_ctrl #(.TIMEOUT(16)) dut (
    .clock     (clock),
    .Reset_n   (Reset_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemOP     (MemOP),
    .Addr      (Addr),
    .WrData    (WrData),
    .MemWait   (MemWait),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .Err       (Err),
    .ErrCode   (ErrCode),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Runs one CU access; called 1ns after a rising edge. waits<0 means memory never acks.
  task automatic run(input logic rd, input logic wr, input logic [1:0] op,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rdat, input int waits);
    int cyc;
    mw_cyc = 0; req_cyc = 0; o_done = 1'b0;
    o_be = '0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
    o_rdv = 1'b0; o_rd = '0; o_err = 1'b0; o_ec = '0;
    MemRead = rd; MemWrite = wr; MemOP = op; Addr = addr; WrData = wd; mem_rdata = rdat;
    cyc = 0;
    while (!o_done && cyc < 64) begin
      mem_ack = mem_req && (req_cyc == waits);
      #1;
      if (MemWait) begin
        mw_cyc++;
        if (mem_req) begin
          if (req_cyc == 0) begin
            o_be = mem_be; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
          end
          req_cyc++;
        end
      end else begin
        o_done = 1'b1;
        o_rdv = RdValid; o_rd = RdData; o_err = Err; o_ec = ErrCode;
      end
      next_cycle();
      cyc++;
    end
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    check("access_completes", {31'b0, o_done}, 32'd1);
  endtask

  initial begin
    Reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOP = 2'b00;
    Addr = '0; WrData = '0; mem_ack = 1'b0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    check("rst_mem_req",   {31'b0, mem_req}, 32'd0);
    check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_be",    {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rddata",    RdData, 32'd0);
    check("rst_rdvalid",   {31'b0, RdValid}, 32'd0);
    check("rst_err",       {31'b0, Err}, 32'd0);
    check("rst_errcode",   {30'b0, ErrCode}, 32'd0);
    Reset_n = 1'b1;
    next_cycle();

    // Word read, zero-wait
    run(1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    check("wr_be",      {28'b0, o_be}, 32'hF);
    check("wr_addr",    o_addr, 32'h100);
    check("wr_we",      {31'b0, o_we}, 32'd0);
    check("wr_req_cyc", req_cyc, 32'd1);
    check("wr_mw_cyc",  mw_cyc, 32'd2);
    check("wr_rdvalid", {31'b0, o_rdv}, 32'd1);
    check("wr_rddata",  o_rd, 32'hDEAD_BEEF);
    check("wr_err",     {31'b0, o_err}, 32'd0);
    #1;
    check("wr_rdvalid_pulse", {31'b0, RdValid}, 32'd0);

    // Byte signed / unsigned reads at offset 3
    run(1'b1, 1'b0, 2'b10, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
    check("bs_be",     {28'b0, o_be}, 32'h1);
    check("bs_addr",   o_addr, 32'h100);
    check("bs_rddata", o_rd, 32'hFFFF_FFF0);
    run(1'b1, 1'b0, 2'b11, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
    check("bu_rddata", o_rd, 32'h0000_00F0);

    // Half write at offset 2, three wait cycles
    run(1'b0, 1'b1, 2'b01, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3);
    check("hw_we",      {31'b0, o_we}, 32'd1);
    check("hw_be",      {28'b0, o_be}, 32'h3);
    check("hw_addr",    o_addr, 32'h200);
    check("hw_wdata",   {16'b0, o_wdata[15:0]}, 32'hABCD);
    check("hw_mw_cyc",  mw_cyc, 32'd5);
    check("hw_rdvalid", {31'b0, o_rdv}, 32'd0);

    // Half signed read at offset 0, byte write at offset 1
    run(1'b1, 1'b0, 2'b01, 32'h0000_0400, 32'h0, 32'h8001_1234, 1);
    check("hr_be",     {28'b0, o_be}, 32'hC);
    check("hr_rddata", o_rd, 32'hFFFF_8001);
    run(1'b0, 1'b1, 2'b10, 32'h0000_0501, 32'h0000_005A, 32'h0, 0);
    check("bw_be",    {28'b0, o_be}, 32'h4);
    check("bw_wdata", {24'b0, o_wdata[23:16]}, 32'h5A);

    // Misaligned word read
    run(1'b1, 1'b0, 2'b00, 32'h0000_0101, 32'h0, 32'h0, 0);
    check("mis_req_cyc", req_cyc, 32'd0);
    check("mis_mw_cyc",  mw_cyc, 32'd1);
    check("mis_err",     {31'b0, o_err}, 32'd1);
    check("mis_errcode", {30'b0, o_ec}, 32'd1);
    check("mis_rdvalid", {31'b0, o_rdv}, 32'd0);
    #1;
    check("mis_err_pulse", {31'b0, Err}, 32'd0);

    // Both strobes
    run(1'b1, 1'b1, 2'b00, 32'h0000_0100, 32'h0, 32'h0, 0);
    check("both_req_cyc", req_cyc, 32'd0);
    check("both_errcode", {30'b0, o_ec}, 32'd3);

    // Bus timeout
    run(1'b1, 1'b0, 2'b00, 32'h0000_0600, 32'h0, 32'h1111_1111, -1);
    check("to_req_cyc", req_cyc, 32'd16);
    check("to_mw_cyc",  mw_cyc, 32'd17);
    check("to_err",     {31'b0, o_err}, 32'd1);
    check("to_errcode", {30'b0, o_ec}, 32'd2);
    check("to_rddata",  o_rd, 32'd0);
    check("to_rdvalid", {31'b0, o_rdv}, 32'd0);

    // ErrCode holds across a later successful access
    run(1'b1, 1'b0, 2'b00, 32'h0000_0700, 32'h0, 32'hCAFE_F00D, 0);
    check("hold_rddata",  o_rd, 32'hCAFE_F00D);
    check("hold_errcode", {30'b0, o_ec}, 32'd2);

    // Asynchronous reset during REQ
    MemRead = 1'b1; MemOP = 2'b00; Addr = 32'h0000_0300; mem_rdata = 32'h1234_5678;
    next_cycle();
    check("arst_req_before", {31'b0, mem_req}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("arst_req_dropped", {31'b0, mem_req}, 32'd0);
    MemRead = 1'b0; mem_ack = 1'b1;
    next_cycle();
    check("arst_no_rdvalid", {31'b0, RdValid}, 32'd0);
    check("arst_no_req",     {31'b0, mem_req}, 32'd0);
    Reset_n = 1'b1; mem_ack = 1'b0;
    next_cycle();
    check("arst_idle_rdvalid", {31'b0, RdValid}, 32'd0);
    run(1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'h0, 32'h1234_5678, 1);
    check("arst_fresh_rddata", o_rd, 32'h1234_5678);
    check("arst_fresh_mw_cyc", mw_cyc, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
